// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and helpers for the front end of the pipeline.
//   XLEN / ILEN       : datapath and instruction widths
//   RESET_PC_DEF      : default reset program counter
//   NOP_INSTR_DEF     : addi x0,x0,0, used as the pipeline bubble
//   align_word()      : clears the two low bits of a byte address
package rv32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings (hazard unit,
// execute redirect, instruction memory, decode stage).
//   master : the fetch stage itself
//   slave  : the environment driving control and the instruction memory
interface fetch_stage_if;
    import rv32i_pkg::*;

    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_instr;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_plus4;
    logic [ILEN-1:0] id_instr;
    logic            misalign_flag;
    logic [31:0]     fetch_count;

    modport master (
        input  stall, redirect_valid, redirect_target, imem_instr,
        output imem_addr, id_valid, id_pc, id_pc_plus4, id_instr, misalign_flag, fetch_count
    );

    modport slave (
        output stall, redirect_valid, redirect_target, imem_instr,
        input  imem_addr, id_valid, id_pc, id_pc_plus4, id_instr, misalign_flag, fetch_count
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : invalidate contents (pc fields hold, instr becomes NOP)
//   hold            : keep current contents (flush has priority)
//   pc_in, pc_plus4_in, instr_in : values captured on a normal advance
//   valid, pc, pc_plus4, instr   : registered outputs to decode
module if_id_reg
    import rv32i_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            hold,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    input  logic [ILEN-1:0] instr_in,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [ILEN-1:0] instr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            pc       <= '0;
            pc_plus4 <= '0;
            instr    <= NOP_INSTR;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (!hold) begin
            valid    <= 1'b1;
            pc       <= pc_in;
            pc_plus4 <= pc_plus4_in;
            instr    <= instr_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: program counter, next-PC selection,
// fetch counter and the IF/ID register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_stage_if.master (stall/redirect in, imem address/data,
//              IF/ID outputs, misalign pulse, fetch counter)
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input logic          clk,
    input logic          rst,
    fetch_stage_if.master bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic            misalign_q;
    logic [31:0]     count_q;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
    end

    // Priority: rst > redirect > stall > advance. Redirect ignores stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else if (bus.redirect_valid) begin
            pc_q       <= align_word(bus.redirect_target);
            misalign_q <= |bus.redirect_target[1:0];
        end else if (bus.stall) begin
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_plus4;
            misalign_q <= 1'b0;
            count_q    <= count_q + 32'd1;
        end
    end

    // Address comes straight from the register: no input-to-imem path.
    assign bus.imem_addr     = pc_q;
    assign bus.misalign_flag = misalign_q;
    assign bus.fetch_count   = count_q;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .flush       (bus.redirect_valid),
        .hold        (bus.stall),
        .pc_in       (pc_q),
        .pc_plus4_in (pc_plus4),
        .instr_in    (bus.imem_instr),
        .valid       (bus.id_valid),
        .pc          (bus.id_pc),
        .pc_plus4    (bus.id_pc_plus4),
        .instr       (bus.id_instr)
    );

endmodule
